// File: rtl/cpu_sequencer.sv
// cpu_sequencer: FETCH/EXEC/WB control with a 4x16 register file that feeds and consumes a 16-bit ALU.
// Define CPU_SEQ_BRANCH_EN to add opcode 0x7 BRZ; without it 0x7 is treated as illegal.
module cpu_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic            instr_req,
    output logic [PC_W-1:0] instr_addr,
    input  logic            instr_ack,
    input  logic [15:0]     instr_data,
    output logic [15:0]     alu_a,
    output logic [15:0]     alu_b,
    output logic [2:0]      alu_op_select,
    input  logic [15:0]     alu_result,
    output logic            wb_en,
    output logic            halted,
    output logic            illegal,
    input  logic [1:0]      dbg_sel,
    output logic [15:0]     dbg_data
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALTED} state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
`ifdef CPU_SEQ_BRANCH_EN
    localparam logic [3:0] OP_BRZ  = 4'h7;
`endif
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_AND  = 3'b101;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic [15:0]     wb_data;
    logic [15:0]     regs [4];

    logic [3:0]  opcode;
    logic [1:0]  rd, rs;
    logic [15:0] imm_z, imm_s, rd_val, rs_val;
    logic [15:0] b_sel;
    logic [2:0]  op_sel;
    logic        ex_writes, ex_legal, in_exec;

    assign opcode = ir[15:12];
    assign rd     = ir[11:10];
    assign rs     = ir[9:8];
    assign imm_z  = {8'h00, ir[7:0]};
    assign imm_s  = {{8{ir[7]}}, ir[7:0]};
    assign rd_val = regs[rd];
    assign rs_val = regs[rs];

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        b_sel     = '0;
        op_sel    = ALU_PASS;
        ex_writes = 1'b0;
        ex_legal  = 1'b1;
        case (opcode)
            OP_NOP, OP_HALT: ;
            OP_LDI:  begin b_sel = imm_z;  ex_writes = 1'b1; end
            OP_ADD:  begin b_sel = rs_val; op_sel = ALU_ADD; ex_writes = 1'b1; end
            OP_XOR:  begin b_sel = rs_val; op_sel = ALU_XOR; ex_writes = 1'b1; end
            OP_OR:   begin b_sel = rs_val; op_sel = ALU_OR;  ex_writes = 1'b1; end
            OP_AND:  begin b_sel = rs_val; op_sel = ALU_AND; ex_writes = 1'b1; end
            OP_ADDI: begin b_sel = imm_s;  op_sel = ALU_ADD; ex_writes = 1'b1; end
`ifdef CPU_SEQ_BRANCH_EN
            OP_BRZ:  b_sel = rd_val;
`endif
            default: ex_legal = 1'b0;
        endcase
    end

    // ALU operands are only live during EXEC so the ALU sees a quiet PASS of zero otherwise.
    assign in_exec       = (state == S_EXEC);
    assign alu_a         = in_exec ? rd_val : '0;
    assign alu_b         = in_exec ? b_sel : '0;
    assign alu_op_select = in_exec ? op_sel : ALU_PASS;
    assign illegal       = in_exec && !ex_legal;
    assign instr_req     = (state == S_FETCH) && !rst;
    assign instr_addr    = pc;
    assign dbg_data      = regs[dbg_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= '0;
            ir      <= '0;
            wb_data <= '0;
            wb_en   <= 1'b0;
            halted  <= 1'b0;
            // NOTE: the register file is small and architecturally cleared, so it takes the reset like any flop.
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            wb_en <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (instr_ack) begin
                        ir    <= instr_data;
                        pc    <= pc + PC_W'(1);
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wb_data <= alu_result;
                    if (opcode == OP_HALT) begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                    end else begin
                        state <= S_WB;
                        wb_en <= ex_writes;
                    end
`ifdef CPU_SEQ_BRANCH_EN
                    if (opcode == OP_BRZ && rd_val == '0) pc <= PC_W'(ir[7:0]);
`endif
                end
                S_WB: begin
                    if (wb_en) regs[rd] <= wb_data;
                    state <= S_FETCH;
                end
                S_HALTED: state <= S_HALTED;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction-level model plus directed programs.
// Honours CPU_SEQ_BRANCH_EN so the same bench covers both builds.
`timescale 1ns/1ps
module tb_cpu_sequencer;
    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            instr_req;
    logic [PC_W-1:0] instr_addr;
    logic            instr_ack = 1'b0;
    logic [15:0]     instr_data = 16'h0000;
    logic [15:0]     alu_a, alu_b, alu_result;
    logic [2:0]      alu_op_select;
    logic            wb_en, halted, illegal;
    logic [1:0]      dbg_sel = 2'd0;
    logic [15:0]     dbg_data;

    cpu_sequencer #(.PC_W(PC_W)) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_ack(instr_ack), .instr_data(instr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op_select(alu_op_select),
        .alu_result(alu_result),
        .wb_en(wb_en), .halted(halted), .illegal(illegal),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // ALU stand-in
    always_comb begin
        case (alu_op_select)
            3'b000:  alu_result = alu_b;
            3'b010:  alu_result = alu_a + alu_b;
            3'b011:  alu_result = alu_a ^ alu_b;
            3'b100:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = alu_a & alu_b;
            default: alu_result = 16'h0000;
        endcase
    end

    // Instruction memory and fetch responder with programmable ack latency
    logic [15:0]     mem [256];
    int              ack_delay = 0;
    bit              stray_ack = 1'b0;
    int              wait_cnt = 0;
    logic [PC_W-1:0] obs_last = '0;

    always @(negedge clk) begin
        if (instr_req === 1'b1) begin
            if (wait_cnt >= ack_delay) begin
                instr_ack  = 1'b1;
                instr_data = mem[instr_addr];
                obs_last   = instr_addr;
            end else begin
                instr_ack  = 1'b0;
                instr_data = 16'h1CAA;
                wait_cnt++;
            end
        end else begin
            wait_cnt   = 0;
            instr_ack  = stray_ack;
            instr_data = 16'h1CAA;
        end
    end

    // Instruction-level reference model: one accepted fetch expands into EXEC and WB expectations
    typedef struct packed {
        logic        req;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic        wb;
        logic        ill;
        logic        halt_next;
        logic        wr;
        logic [1:0]  wr_rd;
        logic [15:0] wr_val;
    } cyc_t;

    cyc_t            q[$];
    logic [15:0]     m_regs [4];
    logic [PC_W-1:0] m_pc = '0;
    bit              m_halt = 1'b0, m_live = 1'b0, in_fetch = 1'b0, pend_wr = 1'b0;
    logic [1:0]      pend_rd = '0;
    logic [15:0]     pend_val = '0;
    int              total = 0, bad = 0;
    int              obs_wb = 0, obs_ill = 0, obs_req = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic accept(input logic [15:0] w);
        cyc_t e, wbr;
        logic [3:0]  opc;
        logic [1:0]  rd, rs;
        logic [7:0]  imm;
        logic [15:0] a, b, v;
        logic [2:0]  op;
        bit          wr, ill, hlt;
        opc = w[15:12]; rd = w[11:10]; rs = w[9:8]; imm = w[7:0];
        m_pc = m_pc + 1'b1;
        a = m_regs[rd]; b = 16'h0; v = 16'h0; op = 3'b000;
        wr = 1'b0; ill = 1'b0; hlt = 1'b0;
        case (opc)
            4'h0: ;
            4'h1: begin b = {8'h00, imm}; v = b; wr = 1'b1; end
            4'h2: begin b = m_regs[rs]; op = 3'b010; v = a + b; wr = 1'b1; end
            4'h3: begin b = m_regs[rs]; op = 3'b011; v = a ^ b; wr = 1'b1; end
            4'h4: begin b = m_regs[rs]; op = 3'b100; v = a | b; wr = 1'b1; end
            4'h5: begin b = m_regs[rs]; op = 3'b101; v = a & b; wr = 1'b1; end
            4'h6: begin b = {{8{imm[7]}}, imm}; op = 3'b010; v = a + b; wr = 1'b1; end
            4'hF: hlt = 1'b1;
`ifdef CPU_SEQ_BRANCH_EN
            4'h7: begin b = a; if (a == 16'h0) m_pc = imm; end
`endif
            default: ill = 1'b1;
        endcase
        e = '0; e.a = a; e.b = b; e.op = op; e.ill = ill; e.halt_next = hlt;
        q.push_back(e);
        if (!hlt) begin
            wbr = '0; wbr.wb = wr; wbr.wr = wr; wbr.wr_rd = rd; wbr.wr_val = v;
            q.push_back(wbr);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
            m_pc = '0; m_halt = 1'b0; pend_wr = 1'b0; m_live = 1'b1;
            q.delete();
            return;
        end
        if (!m_live) return;
        if (pend_wr) begin
            m_regs[pend_rd] = pend_val;
            pend_wr = 1'b0;
        end
        if (in_fetch && instr_ack) accept(instr_data);
    endtask

    task automatic compare();
        cyc_t e;
        if (!m_live) return;
        e = '0;
        in_fetch = 1'b0;
        if (q.size() > 0) e = q.pop_front();
        else if (!m_halt) begin e.req = 1'b1; in_fetch = 1'b1; end
        if (rst) e.req = 1'b0;
        check("instr_req", instr_req, e.req);
        if (e.req) check("instr_addr", instr_addr, m_pc);
        check("alu_a", alu_a, e.a);
        check("alu_b", alu_b, e.b);
        check("alu_op_select", alu_op_select, e.op);
        check("wb_en", wb_en, e.wb);
        check("illegal", illegal, e.ill);
        check("halted", halted, m_halt);
        check("dbg_data", dbg_data, m_regs[dbg_sel]);
        if (wb_en === 1'b1) obs_wb++;
        if (illegal === 1'b1) obs_ill++;
        if (instr_req === 1'b1) obs_req++;
        if (e.wr) begin pend_wr = 1'b1; pend_rd = e.wr_rd; pend_val = e.wr_val; end
        if (e.halt_next) m_halt = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk); model_step();
            @(negedge clk); compare();
        end
    end

    // Stimulus helpers
    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic clear_obs();
        obs_wb = 0; obs_ill = 0; obs_req = 0;
    endtask

    task automatic read_reg(input string name, input logic [1:0] idx, input logic [15:0] exp);
        @(posedge clk); #1 dbg_sel = idx;
        #1 check(name, dbg_data, exp);
    endtask

    task automatic run_to_halt(input string name, input int budget);
        int n = 0;
        while (!m_halt && n < budget) begin @(posedge clk); n++; end
        #1 check({name, "_halted"}, halted, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100us");
        $fatal(1);
    end

    initial begin
        int n;
        // LDI r1,0x34 with zero-wait ack: cycle-exact literals
        fill_mem(); mem[0] = 16'h1434; mem[1] = 16'hF000;
        reset_dut();
        @(negedge clk); #1;
        check("t1_req_c1", instr_req, 1'b1);
        check("t1_addr_c1", instr_addr, 8'h00);
        @(negedge clk); #1;
        check("t1_exec_b", alu_b, 16'h0034);
        check("t1_exec_op", alu_op_select, 3'b000);
        @(negedge clk); #1;
        check("t1_wb_c3", wb_en, 1'b1);
        dbg_sel = 2'd1;
        @(negedge clk); #1;
        check("t1_dbg_r1", dbg_data, 16'h0034);
        run_to_halt("t1", 40);

        // ADD, ADDI sign extension and wrap, rd==rs
        fill_mem();
        mem[0] = 16'h10FF; mem[1] = 16'h1401; mem[2] = 16'h2100; mem[3] = 16'h68FF;
        mem[4] = 16'h6801; mem[5] = 16'h2500; mem[6] = 16'h6CFF; mem[7] = 16'hF000;
        reset_dut();
        run_to_halt("t2", 60);
        read_reg("t2_r0", 2'd0, 16'h0100);
        read_reg("t2_r1", 2'd1, 16'h0002);
        read_reg("t2_r2", 2'd2, 16'h0000);
        read_reg("t2_r3", 2'd3, 16'hFFFF);

        // XOR / OR / AND on fresh copies of 0x0F against 0x3C
        fill_mem();
        mem[0] = 16'h100F; mem[1] = 16'h143C; mem[2] = 16'h180F; mem[3] = 16'h1C0F;
        mem[4] = 16'h3100; mem[5] = 16'h4900; mem[6] = 16'h5D00; mem[7] = 16'hF000;
        reset_dut();
        run_to_halt("t3", 60);
        read_reg("t3_xor", 2'd0, 16'h0033);
        read_reg("t3_or", 2'd2, 16'h003F);
        read_reg("t3_and", 2'd3, 16'h000C);

        // Four-cycle ack delay, stray acks while idle, illegal opcode 0x9
        fill_mem(); mem[0] = 16'h9123; mem[1] = 16'h1455; mem[2] = 16'hF000;
        ack_delay = 4; stray_ack = 1'b1;
        reset_dut();
        clear_obs();
        run_to_halt("t4", 80);
        check("t4_req_cycles", obs_req, 15);
        check("t4_illegal_pulses", obs_ill, 1);
        check("t4_wb_pulses", obs_wb, 1);
        read_reg("t4_r0", 2'd0, 16'h0000);
        read_reg("t4_r1", 2'd1, 16'h0055);
        ack_delay = 0; stray_ack = 1'b0;

        // HALT at address 2, stays halted, reset (also mid-fetch) restarts cleanly
        fill_mem(); mem[0] = 16'h0000; mem[1] = 16'h1877; mem[2] = 16'hF000;
        reset_dut();
        run_to_halt("t5", 40);
        check("t5_halt_addr", obs_last, 8'h02);
        repeat (10) @(posedge clk);
        #1;
        check("t5_still_halted", halted, 1'b1);
        check("t5_no_req", instr_req, 1'b0);
        ack_delay = 4;
        reset_dut();
        read_reg("t5_r2_cleared", 2'd2, 16'h0000);
        @(posedge clk);
        reset_dut();
        ack_delay = 0;
        run_to_halt("t5b", 60);
        read_reg("t5_r2", 2'd2, 16'h0077);

        // Reset during WB of an ADD must suppress the write
        fill_mem(); mem[0] = 16'h1005; mem[1] = 16'h1403; mem[2] = 16'h2100; mem[3] = 16'hF000;
        reset_dut();
        n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk); #1;
            if (wb_en === 1'b1) n++;
        end
        check("t6_third_wb_seen", n, 3);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        read_reg("t6_r0_nowrite", 2'd0, 16'h0000);
        read_reg("t6_r1_cleared", 2'd1, 16'h0000);
        run_to_halt("t6", 40);
        read_reg("t6_r0", 2'd0, 16'h0008);

        // Opcode 0x7: BRZ when enabled, illegal otherwise
        fill_mem();
        mem[0] = 16'h7C10; mem[1] = 16'hF000;
        mem[16] = 16'h1C01; mem[17] = 16'h7C20; mem[18] = 16'hF000;
        reset_dut();
        clear_obs();
        run_to_halt("t7", 60);
`ifdef CPU_SEQ_BRANCH_EN
        check("t7_halt_addr", obs_last, 8'h12);
        check("t7_illegal_pulses", obs_ill, 0);
        read_reg("t7_r3", 2'd3, 16'h0001);
`else
        check("t7_halt_addr", obs_last, 8'h01);
        check("t7_illegal_pulses", obs_ill, 1);
        read_reg("t7_r3", 2'd3, 16'h0000);
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
